alu_control_mdu: RTL



---
 rtl/alu_control_mdu.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_control_mdu.sv
// alu_control_mdu: ALU control decoder plus HI/LO registers and an iterative multiply/divide
// sequencer.
//
// Decode (combinational): aluop/funct -> alu_m (ALU mode), hilo_sel (00 ALU, 01 HI, 10 LO),
// illegal (unknown R-type funct).
// Sequencer: mult/multu (and div/divu when MDU_DIV_EN is defined) run WIDTH shift steps,
// then one fix-up cycle that applies the sign correction and writes HI/LO.
// Optional feature macro: MDU_DIV_EN compiles in the divider and the div/divu decode.
// Without it, div/divu decode as illegal.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   valid             an instruction is in EX this cycle
//   aluop, funct      command and R-type funct field
//   src_a, src_b      rs/rt operands
//   alu_m, hilo_sel   ALU mode and writeback source select
//   hi, lo            HI/LO registers
//   busy, done        sequencer running / single-cycle completion pulse
//   stall             hold EX: HI/LO or MDU instruction while the sequencer is busy
//   illegal           unknown R-type funct
module alu_control_mdu #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned FUNCT_W = 6,
    parameter int unsigned ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid,
    input  logic [2:0]         aluop,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic [ALUOP_W-1:0] alu_m,
    output logic [1:0]         hilo_sel,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               busy,
    output logic               done,
    output logic               stall,
    output logic               illegal
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [ALUOP_W-1:0] ModeAdd  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ModeSub  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ModeAnd  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ModeOr   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ModeXor  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ModeNor  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ModeSlt  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ModeSltu = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ModeSll  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ModeSrl  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ModeSra  = ALUOP_W'(10);

    localparam logic [FUNCT_W-1:0] FnAdd   = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] FnAddu  = FUNCT_W'(6'b100001);
    localparam logic [FUNCT_W-1:0] FnSub   = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] FnSubu  = FUNCT_W'(6'b100011);
    localparam logic [FUNCT_W-1:0] FnAnd   = FUNCT_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] FnOr    = FUNCT_W'(6'b100101);
    localparam logic [FUNCT_W-1:0] FnXor   = FUNCT_W'(6'b100110);
    localparam logic [FUNCT_W-1:0] FnNor   = FUNCT_W'(6'b100111);
    localparam logic [FUNCT_W-1:0] FnSlt   = FUNCT_W'(6'b101010);
    localparam logic [FUNCT_W-1:0] FnSltu  = FUNCT_W'(6'b101011);
    localparam logic [FUNCT_W-1:0] FnSll   = FUNCT_W'(6'b000000);
    localparam logic [FUNCT_W-1:0] FnSrl   = FUNCT_W'(6'b000010);
    localparam logic [FUNCT_W-1:0] FnSra   = FUNCT_W'(6'b000011);
    localparam logic [FUNCT_W-1:0] FnMfhi  = FUNCT_W'(6'b010000);
    localparam logic [FUNCT_W-1:0] FnMthi  = FUNCT_W'(6'b010001);
    localparam logic [FUNCT_W-1:0] FnMflo  = FUNCT_W'(6'b010010);
    localparam logic [FUNCT_W-1:0] FnMtlo  = FUNCT_W'(6'b010011);
    localparam logic [FUNCT_W-1:0] FnMult  = FUNCT_W'(6'b011000);
    localparam logic [FUNCT_W-1:0] FnMultu = FUNCT_W'(6'b011001);
`ifdef MDU_DIV_EN
    localparam logic [FUNCT_W-1:0] FnDiv   = FUNCT_W'(6'b011010);
    localparam logic [FUNCT_W-1:0] FnDivu  = FUNCT_W'(6'b011011);
`endif

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    // Mult: {partial product, remaining multiplier}. Div: {remainder, remaining dividend/quotient}.
    logic [2*WIDTH-1:0]     p_q, p_d;
    logic [WIDTH-1:0]       m_q, m_d;        // multiplicand or divisor magnitude
    logic                   neg_lo_q, neg_lo_d; // product sign or quotient sign
    logic [WIDTH-1:0]       hi_q, hi_d, lo_q, lo_d;
`ifdef MDU_DIV_EN
    logic                   is_div_q, is_div_d;
    logic                   neg_hi_q, neg_hi_d; // remainder sign (dividend sign)
    logic                   dz_q, dz_d;         // divide by zero
    logic                   is_div;
`endif

    logic is_mthi, is_mtlo, is_mul, is_signed, mdu_op, hilo_op, accept;

    // Decode
    always_comb begin
        alu_m     = ModeAdd;
        hilo_sel  = 2'b00;
        illegal   = 1'b0;
        is_mthi   = 1'b0;
        is_mtlo   = 1'b0;
        is_mul    = 1'b0;
        is_signed = 1'b0;
`ifdef MDU_DIV_EN
        is_div    = 1'b0;
`endif
        unique case (aluop)
            3'b000: alu_m = ModeAdd;
            3'b001: alu_m = ModeSub;
            3'b011: alu_m = ModeAnd;
            3'b100: alu_m = ModeOr;
            3'b101: alu_m = ModeXor;
            3'b110: alu_m = ModeSlt;
            3'b111: alu_m = ModeSltu;
            3'b010: begin
                case (funct)
                    FnAdd, FnAddu: alu_m = ModeAdd;
                    FnSub, FnSubu: alu_m = ModeSub;
                    FnAnd:   alu_m = ModeAnd;
                    FnOr:    alu_m = ModeOr;
                    FnXor:   alu_m = ModeXor;
                    FnNor:   alu_m = ModeNor;
                    FnSlt:   alu_m = ModeSlt;
                    FnSltu:  alu_m = ModeSltu;
                    FnSll:   alu_m = ModeSll;
                    FnSrl:   alu_m = ModeSrl;
                    FnSra:   alu_m = ModeSra;
                    FnMfhi:  hilo_sel = 2'b01;
                    FnMflo:  hilo_sel = 2'b10;
                    FnMthi:  is_mthi = 1'b1;
                    FnMtlo:  is_mtlo = 1'b1;
                    FnMult:  begin
                        is_mul    = 1'b1;
                        is_signed = 1'b1;
                    end
                    FnMultu: is_mul = 1'b1;
`ifdef MDU_DIV_EN
                    FnDiv:   begin
                        is_div    = 1'b1;
                        is_signed = 1'b1;
                    end
                    FnDivu:  is_div = 1'b1;
`endif
                    default: illegal = 1'b1;
                endcase
            end
            default: alu_m = ModeAdd;
        endcase
    end

`ifdef MDU_DIV_EN
    assign mdu_op = is_mul | is_div;
`else
    assign mdu_op = is_mul;
`endif
    assign hilo_op = (hilo_sel != 2'b00) | is_mthi | is_mtlo;
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StFix);
    assign stall   = busy & valid & (hilo_op | mdu_op);
    assign accept  = valid & ~busy & mdu_op;
    assign hi      = hi_q;
    assign lo      = lo_q;

    // Operand magnitudes for the unsigned core
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = is_signed & src_a[WIDTH-1];
    assign b_neg = is_signed & src_b[WIDTH-1];
    assign a_mag = a_neg ? -src_a : src_a;
    assign b_mag = b_neg ? -src_b : src_b;

    // One shift-add multiply step
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next, prod_fix;
    assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? m_q : '0)};
    assign mul_next = {mul_sum, p_q[WIDTH-1:1]};
    assign prod_fix = neg_lo_q ? -p_q : p_q;

`ifdef MDU_DIV_EN
    // One restoring divide step; a set top bit of diff means the trial subtract went negative
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] div_next;
    assign div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, m_q};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        m_d      = m_q;
        neg_lo_d = neg_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MDU_DIV_EN
        is_div_d = is_div_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StRun;
                    cnt_d    = CntW'(WIDTH);
                    neg_lo_d = a_neg ^ b_neg;
                    m_d      = a_mag;
                    p_d      = {{WIDTH{1'b0}}, b_mag};
`ifdef MDU_DIV_EN
                    is_div_d = is_div;
                    neg_hi_d = a_neg;
                    dz_d     = (src_b == '0);
                    if (is_div) begin
                        m_d = b_mag;
                        p_d = {{WIDTH{1'b0}}, a_mag};
                    end
`endif
                end else if (valid && is_mthi) begin
                    hi_d = src_a;
                end else if (valid && is_mtlo) begin
                    lo_d = src_a;
                end
            end
            StRun: begin
`ifdef MDU_DIV_EN
                p_d = is_div_q ? div_next : mul_next;
`else
                p_d = mul_next;
`endif
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                {hi_d, lo_d} = prod_fix;
`ifdef MDU_DIV_EN
                // Divide by zero leaves remainder = |dividend|, so the sign fix restores src_a
                if (is_div_q) begin
                    lo_d = dz_q     ? '1 :
                           neg_lo_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
                    hi_d = neg_hi_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            p_q      <= '0;
            m_q      <= '0;
            neg_lo_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MDU_DIV_EN
            is_div_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            m_q      <= m_d;
            neg_lo_q <= neg_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MDU_DIV_EN
            is_div_q <= is_div_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
`endif
        end
    end

endmodule
